// File: rtl/fs_dither_if.sv
// Handshake bundle for the Floyd-Steinberg dither block: frame control,
// pixel input stream, dithered output stream and status.
interface fs_dither_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_pix;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_pix;
    logic [15:0] out_idx;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_idx, busy, done
    );

    modport slave (
        input  start, in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, out_idx, busy, done
    );
endinterface

// File: rtl/fs_dither.sv
// Streaming 1-bit Floyd-Steinberg ditherer, one pixel in flight. Quantization
// error is diffused through a current-row buffer, a next-row buffer and a right-carry.
module fs_dither #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int THRESH = 128
) (
    input  logic        clk,
    input  logic        rst,
    fs_dither_if.slave  bus
);
    localparam int          XW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam logic [15:0] LAST = 16'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q;
    logic [15:0]        idx_q;
    logic signed [10:0] carry_q;
    logic signed [10:0] cur_q [IMG_W];
    logic signed [10:0] nxt_q [IMG_W];
    logic signed [10:0] nxt_upd [IMG_W];
    logic [7:0]         pix_q;
    logic [15:0]        oidx_q;

    logic signed [11:0] v;
    logic [7:0]         vc, q;
    logic signed [8:0]  e;
    logic signed [10:0] r, dl, d, dr;
    logic               last_col, in_xfer, out_xfer;

    function automatic logic [7:0] sat_u8(input logic signed [11:0] s);
        if (s < 12'sd0)        return 8'd0;
        else if (s > 12'sd255) return 8'd255;
        else                   return s[7:0];
    endfunction

    // k*e/16 rounded toward minus infinity (arithmetic shift of the product).
    function automatic logic signed [10:0] diffuse(input logic signed [8:0] err,
                                                   input logic [2:0] k);
        logic signed [12:0] p;
        p = 13'(err) * $signed({10'b0, k});
        return 11'(p >>> 4);
    endfunction

    always_comb begin
        v  = $signed({4'b0, bus.in_pix}) + $signed({cur_q[x_q][10], cur_q[x_q]})
           + $signed({carry_q[10], carry_q});
        vc = sat_u8(v);
        q  = (vc >= 8'(THRESH)) ? 8'd255 : 8'd0;
        e  = $signed({1'b0, vc}) - $signed({1'b0, q});
        r  = diffuse(e, 3'd7);
        dl = diffuse(e, 3'd3);
        d  = diffuse(e, 3'd5);
        dr = diffuse(e, 3'd1);
        last_col = (x_q == XW'(IMG_W - 1));
        nxt_upd  = nxt_q;
        // Index -1 and IMG_W never match, so edge terms fall away naturally.
        for (int i = 0; i < IMG_W; i++) begin
            if (i == int'(x_q) - 1) nxt_upd[i] = nxt_upd[i] + dl;
            if (i == int'(x_q))     nxt_upd[i] = nxt_upd[i] + d;
            if (i == int'(x_q) + 1) nxt_upd[i] = nxt_upd[i] + dr;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_xfer  = (state_q == RUN)  && bus.in_valid;
        out_xfer = (state_q == EMIT) && bus.out_ready;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (in_xfer)   state_d = EMIT;
            EMIT: if (out_xfer)  state_d = (oidx_q == LAST) ? DONE : RUN;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            pix_q   <= '0;
            oidx_q  <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                cur_q[i] <= '0;
                nxt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                x_q     <= '0;
                idx_q   <= '0;
                carry_q <= '0;
                for (int i = 0; i < IMG_W; i++) begin
                    cur_q[i] <= '0;
                    nxt_q[i] <= '0;
                end
            end else if (in_xfer) begin
                pix_q  <= q;
                oidx_q <= idx_q;
                idx_q  <= idx_q + 16'd1;
                if (last_col) begin
                    cur_q   <= nxt_upd;
                    carry_q <= '0;
                    x_q     <= '0;
                    for (int i = 0; i < IMG_W; i++) nxt_q[i] <= '0;
                end else begin
                    nxt_q   <= nxt_upd;
                    carry_q <= r;
                    x_q     <= x_q + XW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out_pix   = pix_q;
    assign bus.out_idx   = oidx_q;
endmodule
